// File: rtl/stack_mem_unit.sv
// Main/return stack storage with entry-count pointers, two request ports and sticky error flags.
// Reads are registered (one-cycle latency); writes and pointer moves commit on the same edge.
module stack_mem_unit #(
    parameter int DATA_W = 16,
    parameter int MS_AW  = 6,
    parameter int RS_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MSPWrite,
    input  logic              MSPop,
    input  logic              RSPWrite,
    input  logic              RSPop,
    input  logic              MemRead1,
    input  logic [1:0]        MemDst1,
    input  logic              MemRead2,
    input  logic              MemWrite2,
    input  logic [1:0]        MemDst2,
    input  logic [1:0]        MemData,
    input  logic [3:0]        off,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] res_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] valb_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid1,
    output logic              rd_valid2,
    output logic [MS_AW:0]    msp,
    output logic [RS_AW:0]    rsp,
    output logic              ms_empty,
    output logic              ms_full,
    output logic              rs_empty,
    output logic              rs_full,
    output logic              ms_ovf,
    output logic              ms_unf,
    output logic              rs_ovf,
    output logic              rs_unf,
    output logic              addr_err
);
    localparam int MS_D = 1 << MS_AW;
    localparam int RS_D = 1 << RS_AW;

    typedef logic [MS_AW:0]   msp_t;
    typedef logic [RS_AW:0]   rsp_t;
    typedef logic [MS_AW-1:0] ms_a_t;
    typedef logic [RS_AW-1:0] rs_a_t;

    logic [DATA_W-1:0] r_ms [MS_D];
    logic [DATA_W-1:0] r_rs [RS_D];
    msp_t              r_msp;
    rsp_t              r_rsp;
    logic [DATA_W-1:0] r_rd1, r_rd2;
    logic              r_v1, r_v2;
    logic              r_ms_ovf, r_ms_unf, r_rs_ovf, r_rs_unf, r_addr_err;

    logic              w_ms_empty, w_ms_full, w_rs_empty, w_rs_full;
    msp_t              w_k1;
    logic              w_ok1;
    ms_a_t             w_a1;
    logic              w_ok2, w_rs2;
    ms_a_t             w_a2;
    rs_a_t             w_ra2;
    logic [DATA_W-1:0] w_wd2, w_rv2;
    logic              w_rd2_req, w_we_ms, w_we_rs, w_addr_ev;
    logic              w_ms_push, w_ms_pop, w_rs_push, w_rs_pop;

    assign w_ms_empty = (r_msp == '0);
    assign w_ms_full  = (r_msp == msp_t'(MS_D));
    assign w_rs_empty = (r_rsp == '0);
    assign w_rs_full  = (r_rsp == rsp_t'(RS_D));

    // Port 1 indexes below the top: depth k is legal only while k < msp.
    always_comb begin
        w_k1  = '0;
        w_ok1 = 1'b1;
        case (MemDst1)
            2'b00:   w_k1 = '0;
            2'b01:   w_k1 = msp_t'(1);
            2'b10:   w_k1 = msp_t'(off);
            default: w_ok1 = 1'b0;
        endcase
        w_ok1 = w_ok1 && (r_msp > w_k1);
        w_a1  = ms_a_t'(r_msp - w_k1 - msp_t'(1));
    end

    // Port 2 targets use the pointers as they stood before this edge.
    always_comb begin
        w_ok2 = 1'b0;
        w_rs2 = 1'b0;
        w_a2  = ms_a_t'(r_msp - msp_t'(1));
        w_ra2 = rs_a_t'(r_rsp - rsp_t'(1));
        case (MemDst2)
            2'b00: w_ok2 = !w_ms_empty;
            2'b01: begin
                w_rs2 = 1'b1;
                w_ok2 = !w_rs_empty;
            end
            2'b10: begin
                w_a2  = ms_a_t'(r_msp);
                w_ok2 = !w_ms_full;
            end
            default: w_ok2 = 1'b0;
        endcase
        case (MemData)
            2'b00:   w_wd2 = pc_in;
            2'b01:   w_wd2 = res_in;
            2'b10:   w_wd2 = imm_in;
            default: w_wd2 = valb_in;
        endcase
    end

    assign w_rv2     = w_rs2 ? r_rs[w_ra2] : r_ms[w_a2];
    assign w_rd2_req = MemRead2 & ~MemWrite2;
    assign w_we_ms   = rst & MemWrite2 & w_ok2 & ~w_rs2;
    assign w_we_rs   = rst & MemWrite2 & w_ok2 & w_rs2;
    assign w_addr_ev = (MemRead1 & ~w_ok1) | ((MemRead2 | MemWrite2) & ~w_ok2);
    assign w_ms_push = MSPWrite & ~MSPop;
    assign w_ms_pop  = MSPWrite & MSPop;
    assign w_rs_push = RSPWrite & ~RSPop;
    assign w_rs_pop  = RSPWrite & RSPop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_msp      <= '0;
            r_rsp      <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_ms_ovf   <= 1'b0;
            r_ms_unf   <= 1'b0;
            r_rs_ovf   <= 1'b0;
            r_rs_unf   <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_ms_push && !w_ms_full)      r_msp <= r_msp + msp_t'(1);
            else if (w_ms_pop && !w_ms_empty) r_msp <= r_msp - msp_t'(1);
            if (w_rs_push && !w_rs_full)      r_rsp <= r_rsp + rsp_t'(1);
            else if (w_rs_pop && !w_rs_empty) r_rsp <= r_rsp - rsp_t'(1);

            r_v1 <= MemRead1;
            if (MemRead1) r_rd1 <= w_ok1 ? r_ms[w_a1] : '0;
            r_v2 <= w_rd2_req;
            if (w_rd2_req) r_rd2 <= w_ok2 ? w_rv2 : '0;

            // A same-cycle error event overrides clr_err.
            r_ms_ovf   <= (r_ms_ovf & ~clr_err) | (w_ms_push & w_ms_full);
            r_ms_unf   <= (r_ms_unf & ~clr_err) | (w_ms_pop & w_ms_empty);
            r_rs_ovf   <= (r_rs_ovf & ~clr_err) | (w_rs_push & w_rs_full);
            r_rs_unf   <= (r_rs_unf & ~clr_err) | (w_rs_pop & w_rs_empty);
            r_addr_err <= (r_addr_err & ~clr_err) | w_addr_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we_ms) r_ms[w_a2]  <= w_wd2;
        if (w_we_rs) r_rs[w_ra2] <= w_wd2;
    end

    assign rd_data1  = r_rd1;
    assign rd_data2  = r_rd2;
    assign rd_valid1 = r_v1;
    assign rd_valid2 = r_v2;
    assign msp       = r_msp;
    assign rsp       = r_rsp;
    assign ms_empty  = w_ms_empty;
    assign ms_full   = w_ms_full;
    assign rs_empty  = w_rs_empty;
    assign rs_full   = w_rs_full;
    assign ms_ovf    = r_ms_ovf;
    assign ms_unf    = r_ms_unf;
    assign rs_ovf    = r_rs_ovf;
    assign rs_unf    = r_rs_unf;
    assign addr_err  = r_addr_err;
endmodule

// File: tb/tb_stack_mem_unit.sv
// Bench for stack_mem_unit: directed vector table, hand-written corner sequences,
// then random traffic checked against an array/counter model of the stacks.
module tb_stack_mem_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        MSPWrite, MSPop, RSPWrite, RSPop;
    logic        MemRead1, MemRead2, MemWrite2, clr_err;
    logic [1:0]  MemDst1, MemDst2, MemData;
    logic [3:0]  off;
    logic [15:0] pc_in, res_in, imm_in, valb_in;
    logic [15:0] rd_data1, rd_data2;
    logic        rd_valid1, rd_valid2;
    logic [6:0]  msp;
    logic [5:0]  rsp;
    logic        ms_empty, ms_full, rs_empty, rs_full;
    logic        ms_ovf, ms_unf, rs_ovf, rs_unf, addr_err;

    int checks = 0;
    int errors = 0;

    stack_mem_unit dut (
        .clk(clk), .rst(rst),
        .MSPWrite(MSPWrite), .MSPop(MSPop), .RSPWrite(RSPWrite), .RSPop(RSPop),
        .MemRead1(MemRead1), .MemDst1(MemDst1), .MemRead2(MemRead2), .MemWrite2(MemWrite2),
        .MemDst2(MemDst2), .MemData(MemData), .off(off),
        .pc_in(pc_in), .res_in(res_in), .imm_in(imm_in), .valb_in(valb_in),
        .clr_err(clr_err), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_valid1(rd_valid1), .rd_valid2(rd_valid2), .msp(msp), .rsp(rsp),
        .ms_empty(ms_empty), .ms_full(ms_full), .rs_empty(rs_empty), .rs_full(rs_full),
        .ms_ovf(ms_ovf), .ms_unf(ms_unf), .rs_ovf(rs_ovf), .rs_unf(rs_unf), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ctl;   // {MSPWrite,MSPop,RSPWrite,RSPop,MemRead1,MemRead2,MemWrite2,clr_err}
        logic [1:0]  d1;
        logic [3:0]  of;
        logic [1:0]  d2;
        logic [1:0]  md;
        logic [15:0] dv;
        int          emsp;
        int          ersp;
        logic        ev1;
        logic [15:0] erd1;
        logic        ev2;
        logic [15:0] erd2;
        logic [4:0]  eerr;  // {ms_ovf,ms_unf,rs_ovf,rs_unf,addr_err}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [7:0] ctl, input logic [1:0] d1, input logic [3:0] of,
                               input logic [1:0] d2, input logic [1:0] md, input logic [15:0] dv,
                               input int emsp, input int ersp, input logic ev1, input logic [15:0] erd1,
                               input logic ev2, input logic [15:0] erd2, input logic [4:0] eerr);
        vec_t t;
        t.ctl = ctl; t.d1 = d1; t.of = of; t.d2 = d2; t.md = md; t.dv = dv;
        t.emsp = emsp; t.ersp = ersp; t.ev1 = ev1; t.erd1 = erd1;
        t.ev2 = ev2; t.erd2 = erd2; t.eerr = eerr;
        return t;
    endfunction

    function automatic logic [4:0] errs();
        return {ms_ovf, ms_unf, rs_ovf, rs_unf, addr_err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic set_src(input logic [1:0] md, input logic [15:0] dv);
        pc_in = dv ^ 16'h1111; res_in = dv ^ 16'h2222;
        imm_in = dv ^ 16'h4444; valb_in = dv ^ 16'h8888;
        case (md)
            2'd0: pc_in = dv;
            2'd1: res_in = dv;
            2'd2: imm_in = dv;
            default: valb_in = dv;
        endcase
    endtask

    task automatic apply(input vec_t t);
        {MSPWrite, MSPop, RSPWrite, RSPop, MemRead1, MemRead2, MemWrite2, clr_err} = t.ctl;
        MemDst1 = t.d1; off = t.of; MemDst2 = t.d2; MemData = t.md;
        set_src(t.md, t.dv);
    endtask

    task automatic idle();
        apply(v(8'h00, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain arrays with integer entry counts.
    logic [15:0] m_ms[64];
    logic [15:0] m_rs[32];
    bit          m_msk[64];
    bit          m_rsk[32];
    int          m_msp, m_rsp;
    logic [15:0] m_rd1, m_rd2;
    bit          m_rd1k, m_rd2k, m_v1, m_v2;
    bit   [4:0]  m_err;

    task automatic model_reset();
        m_msp = 0; m_rsp = 0; m_rd1 = 0; m_rd2 = 0; m_rd1k = 1; m_rd2k = 1;
        m_v1 = 0; m_v2 = 0; m_err = 0;
        for (int i = 0; i < 64; i++) m_msk[i] = 0;
        for (int i = 0; i < 32; i++) m_rsk[i] = 0;
    endtask

    task automatic model_step();
        int k, i1, i2;
        bit ok2, isrs;
        bit [4:0] ev;
        logic [15:0] wd;
        ev = 0;
        m_v1 = MemRead1;
        if (MemRead1) begin
            k = (MemDst1 == 2'd0) ? 0 : (MemDst1 == 2'd1) ? 1 : int'(off);
            i1 = m_msp - 1 - k;
            if (MemDst1 != 2'd3 && i1 >= 0 && i1 < m_msp) begin
                m_rd1 = m_ms[i1]; m_rd1k = m_msk[i1];
            end else begin
                m_rd1 = 0; m_rd1k = 1; ev[0] = 1;
            end
        end
        isrs = 0; ok2 = 0; i2 = 0;
        case (MemDst2)
            2'd0: begin i2 = m_msp - 1; ok2 = (i2 >= 0); end
            2'd1: begin isrs = 1; i2 = m_rsp - 1; ok2 = (i2 >= 0); end
            2'd2: begin i2 = m_msp; ok2 = (m_msp < 64); end
            default: ok2 = 0;
        endcase
        wd = (MemData == 2'd0) ? pc_in : (MemData == 2'd1) ? res_in :
             (MemData == 2'd2) ? imm_in : valb_in;
        m_v2 = 0;
        if (MemWrite2) begin
            if (!ok2) ev[0] = 1;
            else if (isrs) begin m_rs[i2] = wd; m_rsk[i2] = 1; end
            else begin m_ms[i2] = wd; m_msk[i2] = 1; end
        end else if (MemRead2) begin
            m_v2 = 1;
            if (!ok2) begin m_rd2 = 0; m_rd2k = 1; ev[0] = 1; end
            else if (isrs) begin m_rd2 = m_rs[i2]; m_rd2k = m_rsk[i2]; end
            else begin m_rd2 = m_ms[i2]; m_rd2k = m_msk[i2]; end
        end
        if (MSPWrite) begin
            if (!MSPop) begin if (m_msp == 64) ev[4] = 1; else m_msp++; end
            else begin if (m_msp == 0) ev[3] = 1; else m_msp--; end
        end
        if (RSPWrite) begin
            if (!RSPop) begin if (m_rsp == 32) ev[2] = 1; else m_rsp++; end
            else begin if (m_rsp == 0) ev[1] = 1; else m_rsp--; end
        end
        m_err = (clr_err ? 5'b0 : m_err) | ev;
    endtask

    task automatic check_model(input int n);
        chk($sformatf("r%0d msp", n), msp, m_msp);
        chk($sformatf("r%0d rsp", n), rsp, m_rsp);
        chk($sformatf("r%0d valid1", n), rd_valid1, m_v1);
        chk($sformatf("r%0d valid2", n), rd_valid2, m_v2);
        if (m_rd1k) chk($sformatf("r%0d rd_data1", n), rd_data1, m_rd1);
        if (m_rd2k) chk($sformatf("r%0d rd_data2", n), rd_data2, m_rd2);
        chk($sformatf("r%0d errflags", n), errs(), m_err);
        chk($sformatf("r%0d status", n), {ms_empty, ms_full, rs_empty, rs_full},
            {m_msp == 0, m_msp == 64, m_rsp == 0, m_rsp == 32});
    endtask

    initial begin
        logic [15:0] lrd1, lrd2;
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset msp", msp, 0);
        chk("reset rsp", rsp, 0);
        chk("reset rd", {rd_data1, rd_data2}, 0);
        chk("reset valid", {rd_valid1, rd_valid2}, 0);
        chk("reset errflags", errs(), 0);
        chk("reset status", {ms_empty, ms_full, rs_empty, rs_full}, 4'b1010);
        @(negedge clk);
        rst = 1'b1;

        //          ctl          d1 of d2 md dv        msp rsp v1 rd1      v2 rd2      err
        tbl.push_back(v(8'b10000010, 0, 0, 2, 2, 16'h0011, 1, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b10000010, 0, 0, 2, 2, 16'h0022, 2, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b10000010, 0, 0, 2, 2, 16'h0033, 3, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00001000, 0, 0, 0, 0, 16'h0,    3, 0, 1, 16'h0033, 0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00001000, 1, 0, 0, 0, 16'h0,    3, 0, 1, 16'h0022, 0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00001000, 2, 2, 0, 0, 16'h0,    3, 0, 1, 16'h0011, 0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b11001000, 0, 0, 0, 0, 16'h0,    2, 0, 1, 16'h0033, 0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00000010, 0, 0, 0, 1, 16'h0055, 2, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00001100, 0, 0, 0, 0, 16'h0,    2, 0, 1, 16'h0055, 1, 16'h0055, 5'b00000));
        tbl.push_back(v(8'b00100000, 0, 0, 0, 0, 16'h0,    2, 1, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00000010, 0, 0, 1, 0, 16'h0040, 2, 1, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00000100, 0, 0, 1, 0, 16'h0,    2, 1, 0, 16'h0,    1, 16'h0040, 5'b00000));
        tbl.push_back(v(8'b00110000, 0, 0, 0, 0, 16'h0,    2, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00000110, 0, 0, 0, 3, 16'h0077, 2, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00001100, 1, 0, 0, 0, 16'h0,    2, 0, 1, 16'h0011, 1, 16'h0077, 5'b00000));
        tbl.push_back(v(8'b00001000, 2, 2, 0, 0, 16'h0,    2, 0, 1, 16'h0,    0, 16'h0,    5'b00001));
        tbl.push_back(v(8'b00000001, 0, 0, 0, 0, 16'h0,    2, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00001000, 3, 0, 0, 0, 16'h0,    2, 0, 1, 16'h0,    0, 16'h0,    5'b00001));
        tbl.push_back(v(8'b00000101, 0, 0, 3, 0, 16'h0,    2, 0, 0, 16'h0,    1, 16'h0,    5'b00001));
        tbl.push_back(v(8'b00000001, 0, 0, 0, 0, 16'h0,    2, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00001010, 0, 0, 0, 2, 16'h0099, 2, 0, 1, 16'h0077, 0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00001000, 0, 0, 0, 0, 16'h0,    2, 0, 1, 16'h0099, 0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b11000000, 0, 0, 0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b11000000, 0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b11000000, 0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 16'h0,    5'b01000));
        tbl.push_back(v(8'b00000001, 0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b11000001, 0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 16'h0,    5'b01000));
        tbl.push_back(v(8'b00110000, 0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 16'h0,    5'b01010));
        tbl.push_back(v(8'b00000001, 0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00000100, 0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    1, 16'h0,    5'b00001));
        tbl.push_back(v(8'b00000001, 0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 16'h0,    5'b00000));
        tbl.push_back(v(8'b00000100, 0, 0, 2, 0, 16'h0,    0, 0, 0, 16'h0,    1, 16'h0011, 5'b00000));

        lrd1 = 16'h0; lrd2 = 16'h0;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            tick();
            if (tbl[i].ev1) lrd1 = tbl[i].erd1;
            if (tbl[i].ev2) lrd2 = tbl[i].erd2;
            chk($sformatf("t%0d msp", i), msp, tbl[i].emsp);
            chk($sformatf("t%0d rsp", i), rsp, tbl[i].ersp);
            chk($sformatf("t%0d valid", i), {rd_valid1, rd_valid2}, {tbl[i].ev1, tbl[i].ev2});
            chk($sformatf("t%0d rd_data1", i), rd_data1, lrd1);
            chk($sformatf("t%0d rd_data2", i), rd_data2, lrd2);
            chk($sformatf("t%0d errflags", i), errs(), tbl[i].eerr);
            chk($sformatf("t%0d status", i), {ms_empty, ms_full, rs_empty},
                {tbl[i].emsp == 0, tbl[i].emsp == 64, tbl[i].ersp == 0});
        end

        // Fill the main stack, then push and write past full.
        for (int i = 0; i < 64; i++) begin
            apply(v(8'b10000010, 0, 0, 2, 2, 16'h0100 + 16'(i), 0, 0, 0, 0, 0, 0, 0));
            tick();
        end
        chk("fill msp", msp, 64);
        chk("fill full", {ms_full, ms_empty}, 2'b10);
        apply(v(8'b10000010, 0, 0, 2, 2, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("ovf msp", msp, 64);
        chk("ovf errflags", errs(), 5'b10001);
        apply(v(8'b00001000, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("full top", rd_data1, 16'h013F);
        apply(v(8'b00001000, 2, 15, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("full off15", rd_data1, 16'h0130);
        for (int i = 0; i < 59; i++) begin
            apply(v(8'b11000000, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
            tick();
        end
        chk("pop to 5", msp, 5);
        apply(v(8'b00000100, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("rd2 top at 5", rd_data2, 16'h0104);

        // Asynchronous reset in the middle of a push+write cycle.
        apply(v(8'b10001010, 0, 0, 2, 2, 16'hCAFE, 0, 0, 0, 0, 0, 0, 0));
        #3 rst = 1'b0;
        #1;
        chk("async rst msp", msp, 0);
        chk("async rst rd", {rd_data1, rd_data2}, 0);
        chk("async rst valid", {rd_valid1, rd_valid2}, 0);
        chk("async rst errflags", errs(), 0);
        chk("async rst status", {ms_empty, ms_full, rs_empty, rs_full}, 4'b1010);
        tick();
        chk("held rst msp", msp, 0);
        @(negedge clk);
        rst = 1'b1;
        apply(v(8'b00001000, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("post rst rd1", {rd_valid1, rd_data1}, {1'b1, 16'h0});
        chk("post rst errflags", errs(), 5'b00001);

        // Random traffic against the model.
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int n = 0; n < 1600; n++) begin
            MSPWrite  = ($urandom_range(0, 3) != 0);
            MSPop     = ($urandom_range(0, 99) < ((n < 800) ? 30 : 70));
            RSPWrite  = $urandom_range(0, 1) == 1;
            RSPop     = ($urandom_range(0, 99) < ((n < 800) ? 35 : 65));
            MemRead1  = $urandom_range(0, 1) == 1;
            MemDst1   = 2'($urandom_range(0, 3));
            off       = 4'($urandom_range(0, 15));
            MemRead2  = $urandom_range(0, 1) == 1;
            MemWrite2 = $urandom_range(0, 1) == 1;
            MemDst2   = 2'($urandom_range(0, 3));
            MemData   = 2'($urandom_range(0, 3));
            pc_in     = 16'($urandom);
            res_in    = 16'($urandom);
            imm_in    = 16'($urandom);
            valb_in   = 16'($urandom);
            clr_err   = ($urandom_range(0, 15) == 0);
            model_step();
            tick();
            check_model(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
